// File: rtl/segasys1_vid_pkg.sv
//==============================================================================
// Module   : segasys1_vid_pkg
// Purpose  : Default raster timing constants and coordinate types shared with the video block.
// Revision : 1.0
//==============================================================================
`default_nettype none

package segasys1_vid_pkg;

  localparam int c_coord_w        = 9;
  localparam int c_h_total        = 320;
  localparam int c_h_visible      = 256;
  localparam int c_h_sync_start   = 280;
  localparam int c_h_sync_w       = 32;
  localparam int c_v_total        = 260;
  localparam int c_v_visible      = 224;
  localparam int c_v_sync_start   = 236;
  localparam int c_v_sync_w       = 3;
  localparam int c_int_hold       = 64;

  typedef logic [c_coord_w-1:0] coord_t;

  typedef enum logic [0:0] {
    VINT_IDLE   = 1'b0,
    VINT_ASSERT = 1'b1
  } vint_state_e;

  // The hold counter only has to reach INT_HOLD-1.
  function automatic int hold_width(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

endpackage

`default_nettype wire

// File: rtl/segasys1_vint_fsm.sv
//==============================================================================
// Module   : segasys1_vint_fsm
// Purpose  : Vertical interrupt request to the Z80: asserts on the trigger, releases on ack or hold timeout.
// Revision : 1.0
//==============================================================================
`default_nettype none

module segasys1_vint_fsm
  import segasys1_vid_pkg::*;
#(
  parameter int INT_HOLD = c_int_hold
) (
  input  logic VCLKx8,
  input  logic RESET,
  input  logic trig_i,
  input  logic int_ack_i,
  input  logic pclk_en_i,
  output logic int_n_o
);

  localparam int                HOLD_W    = hold_width(INT_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(INT_HOLD - 1);

  vint_state_e       state_q;
  logic [HOLD_W-1:0] hold_q;
  logic              int_n_q;

  // A trigger outranks a simultaneous ack so a fresh frame interrupt is never lost.
  always_ff @(posedge VCLKx8 or posedge RESET) begin
    if (RESET) begin
      state_q <= VINT_IDLE;
      hold_q  <= '0;
      int_n_q <= 1'b1;
    end else if (trig_i) begin
      state_q <= VINT_ASSERT;
      hold_q  <= HOLD_LOAD;
      int_n_q <= 1'b0;
    end else if (state_q == VINT_ASSERT) begin
      if (int_ack_i || (pclk_en_i && (hold_q == '0))) begin
        state_q <= VINT_IDLE;
        int_n_q <= 1'b1;
      end else if (pclk_en_i) begin
        hold_q <= hold_q - HOLD_W'(1);
      end
    end
  end

  assign int_n_o = int_n_q;

endmodule

`default_nettype wire

// File: rtl/segasys1_hvgen.sv
//==============================================================================
// Module   : segasys1_hvgen
// Purpose  : Raster timing generator: PH/PV counters, blanking, sync, field and Z80 vertical interrupt.
//            Optional macro SEGASYS1_HVGEN_POSADJ_EN adds frame-latched sync offsets HOFS/VOFS.
// Revision : 1.0
//==============================================================================
`default_nettype none

module segasys1_hvgen
  import segasys1_vid_pkg::*;
#(
  parameter int H_TOTAL      = c_h_total,
  parameter int H_VISIBLE    = c_h_visible,
  parameter int H_SYNC_START = c_h_sync_start,
  parameter int H_SYNC_W     = c_h_sync_w,
  parameter int V_TOTAL      = c_v_total,
  parameter int V_VISIBLE    = c_v_visible,
  parameter int V_SYNC_START = c_v_sync_start,
  parameter int V_SYNC_W     = c_v_sync_w,
  parameter int INT_HOLD     = c_int_hold
) (
  input  logic         VCLKx8,
  input  logic         RESET,
  input  logic         PCLK_EN,
  input  logic         INT_ACK,
`ifdef SEGASYS1_HVGEN_POSADJ_EN
  input  logic [3:0]   HOFS,
  input  logic [3:0]   VOFS,
`endif
  output logic [8:0]   PH,
  output logic [8:0]   PV,
  output logic         HBLK,
  output logic         VBLANK,
  output logic         HSYNC_N,
  output logic         VSYNC_N,
  output logic         INT_N,
  output logic         FIELD
);

  localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS  = coord_t'(V_VISIBLE);

  if (H_SYNC_START + H_SYNC_W > H_TOTAL) begin : g_bad_hsync
    $error("segasys1_hvgen: H_SYNC_START + H_SYNC_W exceeds H_TOTAL");
  end
  if (V_SYNC_START + V_SYNC_W > V_TOTAL) begin : g_bad_vsync
    $error("segasys1_hvgen: V_SYNC_START + V_SYNC_W exceeds V_TOTAL");
  end

  coord_t     ph_q, ph_d, pv_q, pv_d;
  logic       field_q, field_d;
  logic       hblk_q, hblk_d, vblank_q, vblank_d;
  logic       hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
  logic       w_h_wrap, w_v_wrap, w_trig;
  logic [9:0] w_hs_start, w_vs_start;

  assign w_h_wrap = (ph_q == H_LAST);
  assign w_v_wrap = (pv_q == V_LAST);

  always_comb begin
    ph_d    = ph_q + 9'd1;
    pv_d    = pv_q;
    field_d = field_q;
    if (w_h_wrap) begin
      ph_d = '0;
      if (w_v_wrap) begin
        pv_d    = '0;
        field_d = ~field_q;
      end else begin
        pv_d = pv_q + 9'd1;
      end
    end
  end

`ifdef SEGASYS1_HVGEN_POSADJ_EN
  logic [3:0] hofs_q, hofs_d, vofs_q, vofs_d;

  // Offsets only change at the frame wrap so a frame never tears.
  assign hofs_d = (w_h_wrap && w_v_wrap) ? HOFS : hofs_q;
  assign vofs_d = (w_h_wrap && w_v_wrap) ? VOFS : vofs_q;

  always_ff @(posedge VCLKx8 or posedge RESET) begin
    if (RESET) begin
      hofs_q <= '0;
      vofs_q <= '0;
    end else if (PCLK_EN) begin
      hofs_q <= hofs_d;
      vofs_q <= vofs_d;
    end
  end

  assign w_hs_start = 10'(H_SYNC_START) + {{6{hofs_d[3]}}, hofs_d};
  assign w_vs_start = 10'(V_SYNC_START) + {{6{vofs_d[3]}}, vofs_d};
`else
  assign w_hs_start = 10'(H_SYNC_START);
  assign w_vs_start = 10'(V_SYNC_START);
`endif

  // Decoding the next counter values keeps the flags aligned with PH/PV.
  always_comb begin
    hblk_d    = (ph_d >= H_VIS);
    vblank_d  = (pv_d >= V_VIS);
    hsync_n_d = !(({1'b0, ph_d} >= w_hs_start) && ({1'b0, ph_d} < (w_hs_start + 10'(H_SYNC_W))));
    vsync_n_d = !(({1'b0, pv_d} >= w_vs_start) && ({1'b0, pv_d} < (w_vs_start + 10'(V_SYNC_W))));
  end

  always_ff @(posedge VCLKx8 or posedge RESET) begin
    if (RESET) begin
      ph_q      <= '0;
      pv_q      <= '0;
      field_q   <= 1'b0;
      hblk_q    <= 1'b0;
      vblank_q  <= 1'b0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
    end else if (PCLK_EN) begin
      ph_q      <= ph_d;
      pv_q      <= pv_d;
      field_q   <= field_d;
      hblk_q    <= hblk_d;
      vblank_q  <= vblank_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
    end
  end

  assign w_trig = PCLK_EN && (ph_d == '0) && (pv_d == V_VIS);

  segasys1_vint_fsm #(
    .INT_HOLD (INT_HOLD)
  ) u_vint (
    .VCLKx8    (VCLKx8),
    .RESET     (RESET),
    .trig_i    (w_trig),
    .int_ack_i (INT_ACK),
    .pclk_en_i (PCLK_EN),
    .int_n_o   (INT_N)
  );

  assign PH      = ph_q;
  assign PV      = pv_q;
  assign HBLK    = hblk_q;
  assign VBLANK  = vblank_q;
  assign HSYNC_N = hsync_n_q;
  assign VSYNC_N = vsync_n_q;
  assign FIELD   = field_q;

endmodule

`default_nettype wire

// File: doc/segasys1_hvgen.md
Name: segasys1_hvgen

Overview:
- Upstream raster timing generator for the System 1 video subsystem.
- Produces the pixel/line counters PH/PV consumed by the video block (tile, sprite and colour-mix pipeline), plus display blanking, sync and the Z80 vertical interrupt request.
- Advances on the pixel clock enable PCLK_EN, which the video block generates, so the counters stay phase-locked to its pixel pipeline.

Parameters:
- H_TOTAL, 320, pixel clocks per line (PH counts 0..H_TOTAL-1)
- H_VISIBLE, 256, active pixels per line
- H_SYNC_START, 280, first PH with HSYNC_N low
- H_SYNC_W, 32, HSYNC_N width in pixels
- V_TOTAL, 260, lines per frame (PV counts 0..V_TOTAL-1)
- V_VISIBLE, 224, active lines
- V_SYNC_START, 236, first PV with VSYNC_N low
- V_SYNC_W, 3, VSYNC_N width in lines
- INT_HOLD, 64, maximum INT_N low time in pixel clocks

Ports:
- VCLKx8  in  1  system clock (8x pixel)
- RESET  in  1  reset; asynchronous, active-high
- PCLK_EN  in  1  pixel enable, one VCLKx8 cycle in 8
- INT_ACK  in  1  Z80 interrupt acknowledge pulse (VCLKx8 domain)
- PH  out  9  horizontal pixel counter
- PV  out  9  vertical line counter
- HBLK  out  1  horizontal blank
- VBLANK  out  1  vertical blank
- HSYNC_N  out  1  horizontal sync, active-low
- VSYNC_N  out  1  vertical sync, active-low
- INT_N  out  1  vertical interrupt to CPU, active-low
- FIELD  out  1  toggles once per frame

Behaviour:
- Reset values: PH=0, PV=0, HBLK=0, VBLANK=0, HSYNC_N=1, VSYNC_N=1, INT_N=1, FIELD=0, hold counter=0.
- Reset applies asynchronously at any time, including mid-frame or mid-interrupt. The raster restarts at (0,0) on the first PCLK_EN after release.
- All outputs are registered and change only on a VCLKx8 edge where PCLK_EN=1, except INT_N release by INT_ACK, which acts on any VCLKx8 edge.
- Counter advance on each PCLK_EN:
  - PH<=PH+1.
  - When PH==H_TOTAL-1: PH<=0 and PV<=PV+1.
  - When PV also equals V_TOTAL-1: PV<=0 and FIELD toggles.
- Decodes are computed from the next counter values, so they align with PH/PV with zero added latency:
  - HBLK = PH >= H_VISIBLE
  - VBLANK = PV >= V_VISIBLE
  - HSYNC_N = 0 when H_SYNC_START <= PH < H_SYNC_START+H_SYNC_W
  - VSYNC_N = 0 when V_SYNC_START <= PV < V_SYNC_START+V_SYNC_W
- All comparisons are 9-bit unsigned. Parameters must satisfy sync_start+width <= total; this is checked by an elaboration assertion.
- Interrupt FSM, states IDLE and ASSERT:
  - Trigger: the pixel edge on which (PH,PV) becomes (0,V_VISIBLE).
  - IDLE -> ASSERT on trigger: INT_N<=0, hold counter<=INT_HOLD-1.
  - ASSERT -> IDLE on INT_ACK=1, or on a PCLK_EN with hold counter==0. INT_N<=1.
  - In ASSERT, the hold counter decrements on each PCLK_EN.
  - INT_ACK while IDLE is ignored.
  - Trigger and INT_ACK in the same cycle: trigger wins. Stay or enter ASSERT and reload the counter.
- PCLK_EN held low: all state frozen; INT_ACK still releases INT_N.

Optional Feature:
- Macro SEGASYS1_HVGEN_POSADJ_EN.
- When defined:
  - Adds ports HOFS in 4 and VOFS in 4, both two's-complement.
  - Effective H_SYNC_START+HOFS and V_SYNC_START+VOFS are used for the sync decodes.
  - Offsets are latched only at the frame wrap (PV 259->0, PH 319->0) so the screen never tears mid-frame.
  - Reset value of the latched offsets is 0.
- When undefined: no ports are added and the sync positions are the fixed parameters.

Decomposition:
- Package segasys1_vid_pkg holds the default timing constants (H_TOTAL, V_TOTAL, visible and sync values, INT_HOLD) and the 9-bit coordinate width, shared with the video block.
- One sub-module, segasys1_vint_fsm, implements the interrupt FSM and hold counter. Its inputs are trigger, INT_ACK and PCLK_EN; its output is INT_N.

Test Plan:
- Reset, then PCLK_EN every 8th cycle for 2 frames. Expect PH wraps 319->0 with PV+1; PV wraps 259->0 after 83200 pixels; FIELD toggles each frame.
- Sync and blank check on one line. Expect HBLK rises at PH=256 and falls at PH=0; HSYNC_N low for PH 280..311. On frame: VBLANK high for PV 224..259; VSYNC_N low for PV 236..238.
- Interrupt with no ack. Expect INT_N falls at (0,224) and rises after exactly 64 pixel clocks at (64,224).
- Interrupt with ack. Pulse INT_ACK 10 pixels after assertion; expect INT_N high on the next VCLKx8 edge. An INT_ACK pulse while IDLE leaves INT_N=1.
- Mid-frame reset. Assert RESET at (150,100) for 3 cycles; expect immediate PH=PV=0, INT_N=1, HSYNC_N=1, and a clean restart.
- With SEGASYS1_HVGEN_POSADJ_EN: set HOFS=-4 mid-frame. Expect the current frame's HSYNC_N unchanged at 280; the next frame's HSYNC_N low at PH 276..307.
